cache_write_buffer: RTL and testbench



---
 rtl/cache_write_buffer.sv | 172 +++++++++++++++++
 tb/tb_cache_write_buffer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_write_buffer.sv
// cache_write_buffer
//
// Posted-write buffer between the cache memory-side port and the external
// memory bus. Cache writes are absorbed into a small FIFO and drained to
// memory in the background. Cache reads are answered from the FIFO when an
// entry holds the requested address; otherwise a memory read is issued
// that overtakes the buffered writes.
//
// Ports:
//   clk_i, rst_i          clock (rising edge) and async active-high reset
//   cache_valid_i         cache request, held until cache_ready_o
//   cache_ready_o         request completes this cycle
//   cache_we_i            1 = write, 0 = read
//   cache_adr_i           request word address
//   cache_wdata_i         write data
//   cache_rdata_o         read data, valid with cache_ready_o on a read
//   mem_req_o/mem_gnt_i   memory request handshake
//   mem_we_o              memory write
//   mem_adr_o             memory address
//   mem_wdata_o           memory write data
//   mem_rvalid_i          memory read data valid
//   mem_rdata_i           memory read data
//   wb_empty_o            nothing buffered and no memory transaction active

module cache_write_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cache_valid_i,
    output logic                  cache_ready_o,
    input  logic                  cache_we_i,
    input  logic [ADDR_WIDTH-1:0] cache_adr_i,
    input  logic [DATA_WIDTH-1:0] cache_wdata_i,
    output logic [DATA_WIDTH-1:0] cache_rdata_o,
    output logic                  mem_req_o,
    input  logic                  mem_gnt_i,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_adr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  wb_empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {IDLE, WR_REQ, RD_REQ, RD_WAIT, RD_RESP} state_t;

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] fifo_adr_q  [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_q [DEPTH];
    logic [PTR_W-1:0]      head_q, tail_q;
    logic [CNT_W-1:0]      count_q;

    logic [ADDR_WIDTH-1:0] req_adr_q;
    logic [DATA_WIDTH-1:0] req_data_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  hit;
    logic [DATA_WIDTH-1:0] hit_data;
    logic                  rd_hit, rd_miss, push, pop;

    // Search every live entry from oldest to youngest so the last match,
    // i.e. the youngest write to that address, is the one forwarded.
    always_comb begin
        logic [PTR_W-1:0] idx;
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && (fifo_adr_q[idx] == cache_adr_i)) begin
                hit      = 1'b1;
                hit_data = fifo_data_q[idx];
            end
        end
    end

    assign rd_hit  = cache_valid_i & ~cache_we_i & hit;
    assign rd_miss = cache_valid_i & ~cache_we_i & ~hit;
    assign push    = cache_valid_i & cache_we_i & (count_q < CNT_W'(DEPTH));
    assign pop     = (state_q == WR_REQ) & mem_gnt_i;

    // FIFO storage carries no reset; only entries below count are ever read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_adr_q[tail_q]  <= cache_adr_i;
            fifo_data_q[tail_q] <= cache_wdata_i;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves count alone.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) tail_q <= tail_q + 1'b1;
            if (pop)  head_q <= head_q + 1'b1;
            if (push && !pop)
                count_q <= count_q + 1'b1;
            else if (!push && pop)
                count_q <= count_q - 1'b1;
        end
    end

    // Memory request operands are captured when leaving IDLE so they stay
    // stable for the whole request, whatever happens on the cache side.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_adr_q  <= '0;
            req_data_q <= '0;
            rdata_q    <= '0;
        end else begin
            if (state_q == IDLE) begin
                if (rd_miss) begin
                    req_adr_q  <= cache_adr_i;
                    req_data_q <= '0;
                end else if (count_q != '0) begin
                    req_adr_q  <= fifo_adr_q[head_q];
                    req_data_q <= fifo_data_q[head_q];
                end
            end
            if (state_q == RD_WAIT && mem_rvalid_i)
                rdata_q <= mem_rdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // A pending read miss wins over draining so reads are not stuck behind
    // a full buffer of writes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rd_miss)             state_d = RD_REQ;
                else if (count_q != '0)  state_d = WR_REQ;
            end
            WR_REQ:  if (mem_gnt_i)    state_d = IDLE;
            RD_REQ:  if (mem_gnt_i)    state_d = RD_WAIT;
            RD_WAIT: if (mem_rvalid_i) state_d = RD_RESP;
            RD_RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req_o     = (state_q == WR_REQ) || (state_q == RD_REQ);
        mem_we_o      = (state_q == WR_REQ);
        mem_adr_o     = mem_req_o ? req_adr_q : '0;
        mem_wdata_o   = mem_we_o ? req_data_q : '0;
        cache_ready_o = push | rd_hit | (state_q == RD_RESP);
        if (state_q == RD_RESP)
            cache_rdata_o = rdata_q;
        else if (rd_hit)
            cache_rdata_o = hit_data;
        else
            cache_rdata_o = '0;
        wb_empty_o    = (count_q == '0) && (state_q == IDLE);
    end

endmodule

// File: tb/tb_cache_write_buffer.sv
// tb_cache_write_buffer
//
// Directed bench for cache_write_buffer at DEPTH=4. Inputs change just after
// the falling clock edge; outputs are compared a little later in the same
// half cycle. The memory side (gnt/rvalid) is driven explicitly per vector.

module tb_cache_write_buffer;

    localparam int DW = 32;
    localparam int AW = 16;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          cache_valid_i;
    logic          cache_ready_o;
    logic          cache_we_i;
    logic [AW-1:0] cache_adr_i;
    logic [DW-1:0] cache_wdata_i;
    logic [DW-1:0] cache_rdata_o;
    logic          mem_req_o;
    logic          mem_gnt_i;
    logic          mem_we_o;
    logic [AW-1:0] mem_adr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_rvalid_i;
    logic [DW-1:0] mem_rdata_i;
    logic          wb_empty_o;

    int vecCount = 0;
    int errCount = 0;

    cache_write_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(4)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cache_valid_i(cache_valid_i),
        .cache_ready_o(cache_ready_o),
        .cache_we_i   (cache_we_i),
        .cache_adr_i  (cache_adr_i),
        .cache_wdata_i(cache_wdata_i),
        .cache_rdata_o(cache_rdata_o),
        .mem_req_o    (mem_req_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_we_o     (mem_we_o),
        .mem_adr_o    (mem_adr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .wb_empty_o   (wb_empty_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecCount++;
        if (got !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic we, input logic [AW-1:0] adr,
                                 input logic [DW-1:0] wd);
        cache_valid_i = v;
        cache_we_i    = we;
        cache_adr_i   = adr;
        cache_wdata_i = wd;
        #1;
    endtask

    // Waits (bounded) for a write request, checks it, then grants it.
    task automatic drainExpect(input logic [AW-1:0] adr, input logic [DW-1:0] data);
        int waited = 0;
        while (mem_req_o !== 1'b1 && waited < 10) begin
            tick();
            waited++;
        end
        checkOutput("drain_req", mem_req_o, 1);
        checkOutput("drain_we", mem_we_o, 1);
        checkOutput("drain_adr", mem_adr_o, adr);
        checkOutput("drain_wdata", mem_wdata_o, data);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] a;
        logic [DW-1:0] d1, d2;

        rst_i         = 1'b1;
        cache_valid_i = 1'b0;
        cache_we_i    = 1'b0;
        cache_adr_i   = '0;
        cache_wdata_i = '0;
        mem_gnt_i     = 1'b0;
        mem_rvalid_i  = 1'b0;
        mem_rdata_i   = '0;

        // Reset values
        #12;
        checkOutput("rst_req", mem_req_o, 0);
        checkOutput("rst_we", mem_we_o, 0);
        checkOutput("rst_adr", mem_adr_o, 0);
        checkOutput("rst_wdata", mem_wdata_o, 0);
        checkOutput("rst_empty", wb_empty_o, 1);
        checkOutput("rst_ready", cache_ready_o, 0);
        checkOutput("rst_rdata", cache_rdata_o, 0);
        tick();
        rst_i = 1'b0;
        tick();

        // Single posted write held against a stalled memory
        $display("[TB] single write with stalled grant");
        applyStimulus(1, 1, 16'h0010, 32'hDEADBEEF);
        checkOutput("w1_ready", cache_ready_o, 1);
        tick();
        applyStimulus(0, 0, 0, 0);
        checkOutput("w1_notempty", wb_empty_o, 0);
        checkOutput("w1_req_idle", mem_req_o, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("w1_req", mem_req_o, 1);
            checkOutput("w1_we", mem_we_o, 1);
            checkOutput("w1_adr", mem_adr_o, 16'h0010);
            checkOutput("w1_wdata", mem_wdata_o, 32'hDEADBEEF);
        end
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        checkOutput("w1_empty", wb_empty_o, 1);
        checkOutput("w1_req_done", mem_req_o, 0);

        // Fill the FIFO and check back-pressure on the fifth write
        $display("[TB] full FIFO back-pressure");
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1, 1, AW'(i), 32'hA000_0000 + DW'(i));
            checkOutput("fill_ready", cache_ready_o, 1);
            tick();
        end
        applyStimulus(1, 1, 16'h0005, 32'hA000_0005);
        checkOutput("full_ready", cache_ready_o, 0);
        tick();
        mem_gnt_i = 1'b1;
        checkOutput("full_ready_gnt", cache_ready_o, 0);
        checkOutput("full_head_adr", mem_adr_o, 16'h0001);
        checkOutput("full_head_wdata", mem_wdata_o, 32'hA000_0001);
        tick();
        mem_gnt_i = 1'b0;
        checkOutput("full_accept", cache_ready_o, 1);
        tick();
        applyStimulus(0, 0, 0, 0);
        for (int i = 2; i <= 5; i++)
            drainExpect(AW'(i), 32'hA000_0000 + DW'(i));
        checkOutput("full_empty", wb_empty_o, 1);

        // Forwarding picks the youngest of two writes to one address
        $display("[TB] forwarding youngest duplicate");
        applyStimulus(1, 1, 16'h0020, 32'h11111111);
        tick();
        applyStimulus(1, 1, 16'h0020, 32'h22222222);
        tick();
        applyStimulus(1, 0, 16'h0020, 0);
        checkOutput("fwd_ready", cache_ready_o, 1);
        checkOutput("fwd_rdata", cache_rdata_o, 32'h22222222);
        checkOutput("fwd_no_memrd", mem_req_o & ~mem_we_o, 0);
        tick();
        applyStimulus(0, 0, 0, 0);
        checkOutput("fwd_still_wr", mem_we_o, 1);
        drainExpect(16'h0020, 32'h11111111);
        drainExpect(16'h0020, 32'h22222222);

        // Read miss overtakes buffered writes
        $display("[TB] read miss bypass");
        applyStimulus(1, 1, 16'h0050, 32'h50505050);
        tick();
        applyStimulus(1, 1, 16'h0051, 32'h51515151);
        tick();
        applyStimulus(1, 1, 16'h0052, 32'h52525252);
        tick();
        applyStimulus(1, 0, 16'h0040, 0);
        mem_gnt_i = 1'b1;
        checkOutput("miss_ready0", cache_ready_o, 0);
        checkOutput("miss_drain_adr", mem_adr_o, 16'h0050);
        tick();
        mem_gnt_i = 1'b0;
        checkOutput("miss_idle_req", mem_req_o, 0);
        checkOutput("miss_idle_ready", cache_ready_o, 0);
        tick();
        checkOutput("miss_rd_req", mem_req_o, 1);
        checkOutput("miss_rd_we", mem_we_o, 0);
        checkOutput("miss_rd_adr", mem_adr_o, 16'h0040);
        checkOutput("miss_rd_wdata", mem_wdata_o, 0);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        checkOutput("miss_wait_req", mem_req_o, 0);
        checkOutput("miss_wait_ready", cache_ready_o, 0);
        tick();
        checkOutput("miss_wait2_ready", cache_ready_o, 0);
        tick();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hCAFEF00D;
        checkOutput("miss_wait3_ready", cache_ready_o, 0);
        tick();
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        checkOutput("miss_resp_ready", cache_ready_o, 1);
        checkOutput("miss_resp_rdata", cache_rdata_o, 32'hCAFEF00D);
        tick();
        checkOutput("miss_resp_once", cache_ready_o, 0);
        applyStimulus(0, 0, 0, 0);
        drainExpect(16'h0051, 32'h51515151);
        drainExpect(16'h0052, 32'h52525252);

        // Pointer wrap: repeated two-write / drain rounds with forwarding
        $display("[TB] pointer wrap with forwarding");
        for (int i = 0; i < 10; i++) begin
            a  = 16'h0060 + AW'(i % 3);
            d1 = 32'h1000_0000 | DW'(i);
            d2 = 32'h2000_0000 | DW'(i);
            applyStimulus(1, 1, a, d1);
            checkOutput("wrap_w1_ready", cache_ready_o, 1);
            tick();
            applyStimulus(1, 1, a, d2);
            checkOutput("wrap_w2_ready", cache_ready_o, 1);
            tick();
            applyStimulus(1, 0, a, 0);
            mem_gnt_i = 1'b1;
            checkOutput("wrap_hit1", cache_rdata_o, d2);
            checkOutput("wrap_drain1", mem_wdata_o, d1);
            tick();
            mem_gnt_i = 1'b0;
            checkOutput("wrap_hit2", cache_rdata_o, d2);
            tick();
            mem_gnt_i = 1'b1;
            checkOutput("wrap_hit_pop_rdy", cache_ready_o, 1);
            checkOutput("wrap_hit_pop", cache_rdata_o, d2);
            checkOutput("wrap_drain2", mem_wdata_o, d2);
            tick();
            mem_gnt_i = 1'b0;
            applyStimulus(0, 0, 0, 0);
            checkOutput("wrap_empty", wb_empty_o, 1);
        end

        // Reset while a read is waiting for data, with writes buffered
        $display("[TB] reset during read wait");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1, 16'h0070 + AW'(i), 32'h7000_0000 + DW'(i));
            tick();
        end
        applyStimulus(1, 0, 16'h0090, 0);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        tick();
        checkOutput("rstrd_req_adr", mem_adr_o, 16'h0090);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        checkOutput("rstrd_wait", mem_req_o, 0);
        checkOutput("rstrd_notempty", wb_empty_o, 0);
        rst_i = 1'b1;
        #1;
        checkOutput("rstrd_req", mem_req_o, 0);
        checkOutput("rstrd_empty", wb_empty_o, 1);
        checkOutput("rstrd_ready", cache_ready_o, 0);
        applyStimulus(0, 0, 0, 0);
        tick();
        rst_i = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hBADBAD00;
        tick();
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        checkOutput("late_rvalid_ready", cache_ready_o, 0);
        checkOutput("late_rvalid_rdata", cache_rdata_o, 0);
        checkOutput("late_rvalid_req", mem_req_o, 0);
        checkOutput("late_rvalid_empty", wb_empty_o, 1);
        tick();
        checkOutput("late_rvalid_idle", wb_empty_o, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
